// File: rtl/seven_seg_scan_mux.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_scan_mux
// Description : Time-multiplexed driver for an N-digit common-anode 7-segment
//               display. Digit, decimal-point and enable inputs are captured
//               once per scan frame so an update never tears mid-frame.
//               Optional macro SEVEN_SEG_HEX_DECODE_EN turns codes 10..15 into
//               hex glyphs; when undefined those codes are blanked.
// Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_scan_mux #(
    parameter int N_DIGITS    = 8,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*N_DIGITS-1:0] num,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic [N_DIGITS-1:0]   digit_en,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [N_DIGITS-1:0]   an,
    output logic                  frame_tick
);

    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);

    if (N_DIGITS < 1 || N_DIGITS > 16) begin : g_bad_n_digits
        $error("seven_seg_scan_mux: N_DIGITS must be in 1..16");
    end
    if (REFRESH_DIV < 1) begin : g_bad_refresh_div
        $error("seven_seg_scan_mux: REFRESH_DIV must be >= 1");
    end

    // Active-low {a,b,c,d,e,f,g} glyph for one 4-bit code
    function automatic logic [6:0] decode_digit(input logic [3:0] code);
        logic [6:0] s;
        case (code)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
`ifdef SEVEN_SEG_HEX_DECODE_EN
            4'd10:   s = 7'b0001000;
            4'd11:   s = 7'b1100000;
            4'd12:   s = 7'b0110001;
            4'd13:   s = 7'b1000010;
            4'd14:   s = 7'b0110000;
            4'd15:   s = 7'b0111000;
`endif
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    logic [PRE_W-1:0]      pre_q, pre_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [4*N_DIGITS-1:0] shadow_num_q, shadow_num_d;
    logic [N_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
    logic [N_DIGITS-1:0]   shadow_en_q, shadow_en_d;
    logic                  load_pending_q, load_pending_d;
    logic                  frame_tick_q, frame_tick_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [N_DIGITS-1:0]   an_q, an_d;

    logic                  w_pre_wrap;
    logic                  w_load;
    logic [3:0]            w_code;
    logic                  w_en_sel;
    logic                  w_dp_sel;

    // Prescaler, digit index and frame snapshot next-state
    always_comb begin
        w_pre_wrap     = (pre_q == PRE_LAST);
        w_load         = load_pending_q || (w_pre_wrap && (idx_q == IDX_LAST));
        pre_d          = w_pre_wrap ? '0 : pre_q + PRE_W'(1);
        idx_d          = idx_q;
        if (w_pre_wrap) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
        shadow_num_d   = w_load ? num      : shadow_num_q;
        shadow_dp_d    = w_load ? dp_in    : shadow_dp_q;
        shadow_en_d    = w_load ? digit_en : shadow_en_q;
        load_pending_d = 1'b0;
        frame_tick_d   = w_load;
    end

    // Select the current digit from the snapshot and build the pin pattern
    always_comb begin
        w_code   = 4'h0;
        w_en_sel = 1'b0;
        w_dp_sel = 1'b0;
        an_d     = '1;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                w_code   = shadow_num_q[4*k +: 4];
                w_en_sel = shadow_en_q[k];
                w_dp_sel = shadow_dp_q[k];
            end
        end
        seg_d = 7'b1111111;
        dp_d  = 1'b1;
        if (w_en_sel) begin
            for (int k = 0; k < N_DIGITS; k++) begin
                an_d[k] = (idx_q != IDX_W'(k));
            end
            seg_d = decode_digit(w_code);
            dp_d  = ~w_dp_sel;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q          <= '0;
            idx_q          <= '0;
            shadow_num_q   <= '0;
            shadow_dp_q    <= '0;
            shadow_en_q    <= '0;
            load_pending_q <= 1'b1;
            frame_tick_q   <= 1'b0;
            seg_q          <= 7'b1111111;
            dp_q           <= 1'b1;
            an_q           <= '1;
        end else begin
            pre_q          <= pre_d;
            idx_q          <= idx_d;
            shadow_num_q   <= shadow_num_d;
            shadow_dp_q    <= shadow_dp_d;
            shadow_en_q    <= shadow_en_d;
            load_pending_q <= load_pending_d;
            frame_tick_q   <= frame_tick_d;
            seg_q          <= seg_d;
            dp_q           <= dp_d;
            an_q           <= an_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_tick = frame_tick_q;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_seven_seg_scan_mux
// Description : Directed bench for seven_seg_scan_mux: a 4-digit, divide-by-4
//               instance and a 1-digit, divide-by-1 instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seven_seg_scan_mux;

    localparam logic [6:0] c_blank = 7'b1111111;
    localparam logic [6:0] c_s0 = 7'b0000001;
    localparam logic [6:0] c_s1 = 7'b1001111;
    localparam logic [6:0] c_s2 = 7'b0010010;
    localparam logic [6:0] c_s3 = 7'b0000110;
    localparam logic [6:0] c_s4 = 7'b1001100;
    localparam logic [6:0] c_s5 = 7'b0100100;
    localparam logic [6:0] c_s6 = 7'b0100000;
    localparam logic [6:0] c_s7 = 7'b0001111;
    localparam logic [6:0] c_s8 = 7'b0000000;
    localparam logic [6:0] c_s9 = 7'b0000100;
`ifdef SEVEN_SEG_HEX_DECODE_EN
    localparam logic [6:0] c_sA = 7'b0001000;
    localparam logic [6:0] c_sF = 7'b0111000;
`else
    localparam logic [6:0] c_sA = 7'b1111111;
    localparam logic [6:0] c_sF = 7'b1111111;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] num;
    logic [3:0]  dp_in;
    logic [3:0]  digit_en;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_tick;

    logic        reset1;
    logic [3:0]  num1;
    logic [0:0]  dp_in1;
    logic [0:0]  digit_en1;
    logic [6:0]  seg1;
    logic        dp1;
    logic [0:0]  an1;
    logic        frame_tick1;

    int          n_compared = 0;
    int          n_mismatched = 0;
    int          cyc = 0;

    always #5 clk = ~clk;

    seven_seg_scan_mux #(.N_DIGITS(4), .REFRESH_DIV(4)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .num        (num),
        .dp_in      (dp_in),
        .digit_en   (digit_en),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_tick (frame_tick)
    );

    seven_seg_scan_mux #(.N_DIGITS(1), .REFRESH_DIV(1)) u_dut_min (
        .clk        (clk),
        .reset      (reset1),
        .num        (num1),
        .dp_in      (dp_in1),
        .digit_en   (digit_en1),
        .seg        (seg1),
        .dp         (dp1),
        .an         (an1),
        .frame_tick (frame_tick1)
    );

    // Count one comparison and report it when observed differs from expected
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %b expected %b", tag, got[12:0], exp[12:0]);
        end
    endtask

    // Advance one clock and sample just after the active edge
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Run up to edge number c (counted from reset release) and check the pins
    task automatic at(input int c, input string tag, input logic [3:0] an_e,
                      input logic [6:0] seg_e, input logic dp_e, input logic ft_e);
        while (cyc < c) tick();
        check_val(tag, {19'd0, an, seg, dp, frame_tick}, {19'd0, an_e, seg_e, dp_e, ft_e});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset     = 1'b1;
        num       = 16'h1234;
        dp_in     = 4'b0000;
        digit_en  = 4'b1111;
        reset1    = 1'b1;
        num1      = 4'h7;
        dp_in1    = 1'b1;
        digit_en1 = 1'b1;

        // Reset held for three cycles: everything dark
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("reset_hold", {19'd0, an, seg, dp, frame_tick},
                      {19'd0, 4'b1111, c_blank, 1'b1, 1'b0});
        end

        // Release; snapshot loads on the first edge, first digit after the next
        reset = 1'b0;
        cyc   = 0;
        at(1,  "first_tick",   4'b1111, c_blank, 1'b1, 1'b1);
        at(2,  "first_dig0",   4'b1110, c_s4,    1'b1, 1'b0);
        at(4,  "dig0_hold",    4'b1110, c_s4,    1'b1, 1'b0);
        at(5,  "dig1_3",       4'b1101, c_s3,    1'b1, 1'b0);
        num = 16'h5678;
        at(9,  "dig2_2",       4'b1011, c_s2,    1'b1, 1'b0);
        at(13, "dig3_1",       4'b0111, c_s1,    1'b1, 1'b0);
        at(15, "pre_wrap",     4'b0111, c_s1,    1'b1, 1'b0);
        at(16, "frame1_tick",  4'b0111, c_s1,    1'b1, 1'b1);

        // Scan order and period with 5678
        at(17, "scan_d0_8",    4'b1110, c_s8,    1'b1, 1'b0);
        at(20, "scan_d0_end",  4'b1110, c_s8,    1'b1, 1'b0);
        at(21, "scan_d1_7",    4'b1101, c_s7,    1'b1, 1'b0);
        at(25, "scan_d2_6",    4'b1011, c_s6,    1'b1, 1'b0);
        at(29, "scan_d3_5",    4'b0111, c_s5,    1'b1, 1'b0);
        num = 16'h1111;
        at(31, "no_tick_31",   4'b0111, c_s5,    1'b1, 1'b0);
        at(32, "frame2_tick",  4'b0111, c_s5,    1'b1, 1'b1);
        at(33, "no_tick_33",   4'b1110, c_s1,    1'b1, 1'b0);

        // Tear-free: change to 9999 while digit 1 is being scanned
        at(37, "tear_d1",      4'b1101, c_s1,    1'b1, 1'b0);
        num = 16'h9999;
        at(41, "tear_d2",      4'b1011, c_s1,    1'b1, 1'b0);
        at(45, "tear_d3",      4'b0111, c_s1,    1'b1, 1'b0);
        at(48, "frame3_tick",  4'b0111, c_s1,    1'b1, 1'b1);
        at(49, "upd_d0_9",     4'b1110, c_s9,    1'b1, 1'b0);
        at(53, "upd_d1_9",     4'b1101, c_s9,    1'b1, 1'b0);

        // Blanking and decimal point (takes effect at the frame 4 snapshot)
        digit_en = 4'b0101;
        dp_in    = 4'b0100;
        at(57, "pre_blank_d2", 4'b1011, c_s9,    1'b1, 1'b0);
        at(65, "blk_d0",       4'b1110, c_s9,    1'b1, 1'b0);
        at(69, "blk_d1",       4'b1111, c_blank, 1'b1, 1'b0);
        at(73, "blk_d2_dp",    4'b1011, c_s9,    1'b0, 1'b0);
        at(77, "blk_d3",       4'b1111, c_blank, 1'b1, 1'b0);

        // Non-BCD codes
        num      = 16'h00AF;
        digit_en = 4'b1111;
        dp_in    = 4'b0000;
        at(80, "frame5_tick",  4'b1111, c_blank, 1'b1, 1'b1);
        at(81, "hex_F",        4'b1110, c_sF,    1'b1, 1'b0);
        at(85, "hex_A",        4'b1101, c_sA,    1'b1, 1'b0);
        at(89, "hex_d2_0",     4'b1011, c_s0,    1'b1, 1'b0);

        // Reset while digit 2 is active, then a fresh scan from digit 0
        reset = 1'b1;
        num   = 16'h1234;
        tick();
        check_val("midreset", {19'd0, an, seg, dp, frame_tick},
                  {19'd0, 4'b1111, c_blank, 1'b1, 1'b0});
        reset = 1'b0;
        cyc   = 0;
        at(1,  "rst2_tick",    4'b1111, c_blank, 1'b1, 1'b1);
        at(2,  "rst2_d0_4",    4'b1110, c_s4,    1'b1, 1'b0);
        at(5,  "rst2_d1_3",    4'b1101, c_s3,    1'b1, 1'b0);

        // One digit, divide-by-one instance
        check_val("min_reset", {20'd0, an1, seg1, dp1, frame_tick1},
                  {20'd0, 1'b1, c_blank, 1'b1, 1'b0});
        reset1 = 1'b0;
        tick();
        check_val("min_e1", {20'd0, an1, seg1, dp1, frame_tick1},
                  {20'd0, 1'b1, c_blank, 1'b1, 1'b1});
        for (int i = 2; i <= 4; i++) begin
            tick();
            check_val("min_lit7", {20'd0, an1, seg1, dp1, frame_tick1},
                      {20'd0, 1'b0, c_s7, 1'b0, 1'b1});
        end
        num1 = 4'h3;
        tick();
        check_val("min_lag", {20'd0, an1, seg1, dp1, frame_tick1},
                  {20'd0, 1'b0, c_s7, 1'b0, 1'b1});
        tick();
        check_val("min_lit3", {20'd0, an1, seg1, dp1, frame_tick1},
                  {20'd0, 1'b0, c_s3, 1'b0, 1'b1});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
`default_nettype wire
